dram_req_scheduler: RTL and testbench

Front-end scheduler for the DRAM controller FSM. Arbitrates `NUM_REQ` requesters round-robin and presents one address (bank/row/col) at a time with an `addr_val` pulse. Owns the refresh interval timer and drives `refresh_flag` into the controller: refresh waits for an idle slot, or preempts an access once it becomes urgent. Sits between the host request ports and the controller FSM; one outstanding access at a time.

---
 rtl/dram_req_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_dram_req_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_scheduler.sv
// Round-robin front end for the DRAM controller: one access in flight, refresh timer, urgent-refresh preemption.
// gnt one cycle after req is sampled in IDLE, addr_val one cycle later; requesters hold req until granted.
module dram_req_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int NUMBER_OF_BANKS  = 8,
    parameter int NUMBER_OF_ROWS   = 128,
    parameter int NUMBER_OF_COLS   = 8,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_URGENT   = 64,
    localparam int BW = $clog2(NUMBER_OF_BANKS),
    localparam int RW = $clog2(NUMBER_OF_ROWS),
    localparam int CW = $clog2(NUMBER_OF_COLS),
    localparam int AW = BW + RW + CW
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  addr_val,
    output logic [BW-1:0]         bank_id,
    output logic [RW-1:0]         row_id,
    output logic [CW-1:0]         col_id,
    input  logic                  access_done,
    output logic                  refresh_flag,
    input  logic                  refresh_ack,
    output logic                  refresh_miss,
    output logic                  busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam int UW = (REFRESH_URGENT < 1) ? 1 : $clog2(REFRESH_URGENT + 1);
    localparam logic [TW-1:0] REF_RELOAD = TW'(REFRESH_INTERVAL - 1);
    localparam logic [UW-1:0] URG_MAX    = UW'(REFRESH_URGENT);
    localparam logic [PW-1:0] LAST_REQ   = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_REFRESH,
        S_PREEMPT
    } state_t;

    typedef struct packed {
        logic [BW-1:0] bank;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } addr_t;

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        win;
    logic                 win_vld;
    logic                 take;
    addr_t                addr_q;
    logic [TW-1:0]        ref_cnt;
    logic                 ref_pend;
    logic                 ref_expire;
    logic                 ref_done;
    logic [UW-1:0]        urg_cnt;
    logic                 done_seen;
    logic [NUM_REQ-1:0]   gnt_d;
    logic                 addr_val_d;
    logic                 refresh_flag_d;
    logic                 busy_d;

    // Round-robin pick: first asserted req scanning upward from rr_ptr with wrap.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PW'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    assign ref_expire = (ref_cnt == '0);
    assign ref_done   = refresh_ack && ((state == S_REFRESH) || (state == S_PREEMPT));

    // Refresh bookkeeping; a new expiry wins over an ack in the same cycle.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            ref_cnt      <= REF_RELOAD;
            ref_pend     <= 1'b0;
            urg_cnt      <= '0;
            refresh_miss <= 1'b0;
        end else begin
            refresh_miss <= ref_expire && ref_pend;
            if (ref_expire) begin
                ref_cnt <= REF_RELOAD;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
            if (ref_expire) begin
                ref_pend <= 1'b1;
            end else if (ref_done) begin
                ref_pend <= 1'b0;
            end
            if (!ref_pend) begin
                urg_cnt <= '0;
            end else if (urg_cnt != URG_MAX) begin
                urg_cnt <= urg_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ref_pend) begin
                    state_nxt = S_REFRESH;
                end else if (win_vld) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_BUSY;
            S_BUSY: begin
                if (access_done) begin
                    state_nxt = S_IDLE;
                end else if (ref_pend && (urg_cnt == URG_MAX)) begin
                    state_nxt = S_PREEMPT;
                end
            end
            // An access that finished while preempted goes straight back to IDLE.
            S_PREEMPT: begin
                if (refresh_ack) begin
                    state_nxt = (done_seen || access_done) ? S_IDLE : S_BUSY;
                end
            end
            S_REFRESH: begin
                if (refresh_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        take           = (state == S_IDLE) && !ref_pend && win_vld;
        gnt_d          = take ? (NUM_REQ'(1) << win) : '0;
        addr_val_d     = (state == S_ISSUE);
        refresh_flag_d = (state_nxt == S_REFRESH) || (state_nxt == S_PREEMPT);
        busy_d         = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            gnt          <= '0;
            addr_val     <= 1'b0;
            refresh_flag <= 1'b0;
            busy         <= 1'b0;
            addr_q       <= '0;
            rr_ptr       <= '0;
            done_seen    <= 1'b0;
        end else begin
            gnt          <= gnt_d;
            addr_val     <= addr_val_d;
            refresh_flag <= refresh_flag_d;
            busy         <= busy_d;
            done_seen    <= (state == S_PREEMPT) ? (done_seen || access_done) : 1'b0;
            if (take) begin
                addr_q <= addr_t'(req_addr[int'(win)*AW +: AW]);
                rr_ptr <= (win == LAST_REQ) ? '0 : win + 1'b1;
            end
        end
    end

    assign bank_id = addr_q.bank;
    assign row_id  = addr_q.row;
    assign col_id  = addr_q.col;

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Scoreboard bench for dram_req_scheduler: directed stimulus pushes expected output events, a negedge monitor matches them.
module tb_dram_req_scheduler;
    localparam int NR = 4;
    localparam int AW = 13;

    localparam int K_GNT   = 0;
    localparam int K_ADDR  = 1;
    localparam int K_BRISE = 2;
    localparam int K_BFALL = 3;
    localparam int K_FRISE = 4;
    localparam int K_FFALL = 5;
    localparam int K_MISS  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic             access_done = 1'b0;
    logic             refresh_ack = 1'b0;
    logic [NR-1:0]    gnt;
    logic             addr_val;
    logic [2:0]       bank_id;
    logic [6:0]       row_id;
    logic [2:0]       col_id;
    logic             refresh_flag;
    logic             refresh_miss;
    logic             busy;

    int cyc;
    int n_cmp  = 0;
    int n_fail = 0;
    int n_addr = 0;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    dram_req_scheduler #(
        .NUM_REQ(NR),
        .NUMBER_OF_BANKS(8),
        .NUMBER_OF_ROWS(128),
        .NUMBER_OF_COLS(8),
        .REFRESH_INTERVAL(64),
        .REFRESH_URGENT(4)
    ) dut (
        .clk(clk),
        .rst_b(rst),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .addr_val(addr_val),
        .bank_id(bank_id),
        .row_id(row_id),
        .col_id(col_id),
        .access_done(access_done),
        .refresh_flag(refresh_flag),
        .refresh_ack(refresh_ack),
        .refresh_miss(refresh_miss),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges since the latest reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic string kname(int k);
        case (k)
            K_GNT:   return "gnt";
            K_ADDR:  return "addr_val";
            K_BRISE: return "busy_rise";
            K_BFALL: return "busy_fall";
            K_FRISE: return "refresh_flag_rise";
            K_FFALL: return "refresh_flag_fall";
            default: return "refresh_miss";
        endcase
    endfunction

    function automatic logic [AW-1:0] pack(int b, int r, int c);
        logic [2:0] bb;
        logic [6:0] rr;
        logic [2:0] cc;
        bb = b[2:0];
        rr = r[6:0];
        cc = c[2:0];
        return {bb, rr, cc};
    endfunction

    task automatic expect_ev(int k, int d, int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(string nm, int act, int ex);
        n_cmp++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
        end
    endtask

    task automatic match_ev(int k, int d);
        int hit;
        hit = -1;
        foreach (exp_q[i]) begin
            if (hit < 0 && exp_q[i].kind == k) hit = i;
        end
        n_cmp++;
        if (hit < 0) begin
            n_fail++;
            $display("FAIL unexpected %s: data=%0d at cycle %0d, none expected", kname(k), d, cyc);
        end else begin
            if (exp_q[hit].data != d || exp_q[hit].cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: got data=%0d cycle=%0d, expected data=%0d cycle=%0d",
                         kname(k), d, cyc, exp_q[hit].data, exp_q[hit].cyc);
            end
            exp_q.delete(hit);
        end
    endtask

    task automatic drain();
        ev_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing %s: expected data=%0d at cycle %0d, never seen", kname(e.kind), e.data, e.cyc);
        end
    endtask

    task automatic at_cycle(int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic set_addr(int i, int b, int r, int c);
        req_addr[i*AW +: AW] = pack(b, r, c);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req         = '0;
        access_done = 1'b0;
        refresh_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: turns output activity into events and matches them against the expected queue.
    initial begin
        logic busy_p;
        logic flag_p;
        busy_p = 1'b0;
        flag_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_p = 1'b0;
                flag_p = 1'b0;
            end else begin
                if (gnt != '0) match_ev(K_GNT, int'(gnt));
                if (addr_val) begin
                    n_addr++;
                    match_ev(K_ADDR, int'({bank_id, row_id, col_id}));
                end
                if (busy && !busy_p) match_ev(K_BRISE, 0);
                if (!busy && busy_p) match_ev(K_BFALL, 0);
                if (refresh_flag && !flag_p) match_ev(K_FRISE, 0);
                if (!refresh_flag && flag_p) match_ev(K_FFALL, 0);
                if (refresh_miss) match_ev(K_MISS, 0);
                busy_p = busy;
                flag_p = refresh_flag;
            end
        end
    end

    initial begin
        int g;
        int w;
        int base;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_gnt", int'(gnt), 0);
        check("reset_addr_val", int'(addr_val), 0);
        check("reset_bank", int'(bank_id), 0);
        check("reset_row", int'(row_id), 0);
        check("reset_col", int'(col_id), 0);
        check("reset_refresh_flag", int'(refresh_flag), 0);
        check("reset_refresh_miss", int'(refresh_miss), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Single requester on port 2
        expect_ev(K_GNT, 4, 3);
        expect_ev(K_BRISE, 0, 3);
        expect_ev(K_ADDR, int'(pack(3, 5, 6)), 4);
        expect_ev(K_BFALL, 0, 7);
        at_cycle(2);
        set_addr(2, 3, 5, 6);
        req = 4'b0100;
        at_cycle(3);
        req = '0;
        at_cycle(6);
        access_done = 1'b1;
        at_cycle(7);
        access_done = 1'b0;
        at_cycle(8);
        check("held_bank", int'(bank_id), 3);
        check("held_row", int'(row_id), 5);
        check("held_col", int'(col_id), 6);
        at_cycle(9);
        access_done = 1'b1;
        at_cycle(10);
        access_done = 1'b0;
        at_cycle(14);
        drain();

        // Fairness: all four held, done 4 cycles after each addr_val
        do_reset();
        for (int i = 0; i < NR; i++) set_addr(i, i + 1, 20 + i, 7 - i);
        for (int k = 0; k < 5; k++) begin
            g = 2 + 6 * k;
            w = k % 4;
            expect_ev(K_GNT, 1 << w, g);
            expect_ev(K_BRISE, 0, g);
            expect_ev(K_ADDR, int'(pack(w + 1, 20 + w, 7 - w)), g + 1);
            expect_ev(K_BFALL, 0, g + 5);
        end
        at_cycle(1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 2 + 6 * k;
            if (k == 4) begin
                at_cycle(g);
                req = '0;
            end
            at_cycle(g + 4);
            access_done = 1'b1;
            at_cycle(g + 5);
            access_done = 1'b0;
        end
        at_cycle(36);
        drain();

        // Idle refresh: pending at edge 64, flag at 65, ack drops it
        do_reset();
        expect_ev(K_FRISE, 0, 65);
        expect_ev(K_BRISE, 0, 65);
        expect_ev(K_FFALL, 0, 69);
        expect_ev(K_BFALL, 0, 69);
        at_cycle(68);
        refresh_ack = 1'b1;
        at_cycle(69);
        refresh_ack = 1'b0;
        at_cycle(75);
        drain();

        // Preemption of a long access by an urgent refresh
        do_reset();
        expect_ev(K_GNT, 2, 59);
        expect_ev(K_BRISE, 0, 59);
        expect_ev(K_ADDR, int'(pack(5, 100, 2)), 60);
        expect_ev(K_FRISE, 0, 69);
        expect_ev(K_FFALL, 0, 72);
        expect_ev(K_BFALL, 0, 76);
        at_cycle(58);
        set_addr(1, 5, 100, 2);
        req = 4'b0010;
        at_cycle(59);
        req = '0;
        at_cycle(71);
        refresh_ack = 1'b1;
        at_cycle(72);
        refresh_ack = 1'b0;
        at_cycle(73);
        check("resume_busy", int'(busy), 1);
        check("resume_bank", int'(bank_id), 5);
        check("resume_row", int'(row_id), 100);
        check("resume_col", int'(col_id), 2);
        at_cycle(75);
        access_done = 1'b1;
        at_cycle(76);
        access_done = 1'b0;
        at_cycle(80);
        drain();

        // Missed refresh and refresh-over-request priority
        do_reset();
        expect_ev(K_FRISE, 0, 65);
        expect_ev(K_BRISE, 0, 65);
        expect_ev(K_MISS, 0, 128);
        expect_ev(K_FFALL, 0, 131);
        expect_ev(K_BFALL, 0, 131);
        expect_ev(K_GNT, 8, 132);
        expect_ev(K_BRISE, 0, 132);
        expect_ev(K_ADDR, int'(pack(7, 127, 7)), 133);
        expect_ev(K_BFALL, 0, 137);
        at_cycle(64);
        set_addr(3, 7, 127, 7);
        req = 4'b1000;
        at_cycle(130);
        refresh_ack = 1'b1;
        at_cycle(131);
        refresh_ack = 1'b0;
        at_cycle(132);
        req = '0;
        at_cycle(136);
        access_done = 1'b1;
        at_cycle(137);
        access_done = 1'b0;
        at_cycle(142);
        drain();

        // Asynchronous reset in the middle of an access
        do_reset();
        expect_ev(K_GNT, 1, 3);
        expect_ev(K_BRISE, 0, 3);
        expect_ev(K_ADDR, int'(pack(1, 2, 3)), 4);
        at_cycle(2);
        set_addr(0, 1, 2, 3);
        req = 4'b0001;
        at_cycle(3);
        req = '0;
        at_cycle(6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_addr_val", int'(addr_val), 0);
        check("arst_bank", int'(bank_id), 0);
        check("arst_row", int'(row_id), 0);
        check("arst_col", int'(col_id), 0);
        check("arst_refresh_flag", int'(refresh_flag), 0);
        check("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();
        base = n_addr;
        repeat (12) @(negedge clk);
        check("no_replay_addr_val", n_addr - base, 0);
        check("idle_after_arst_busy", int'(busy), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
